// File: rtl/cluster_scheduler.sv
// Serialises one frame of per-pad cluster candidates into {cnt,adr} words, lowest pad first.
// Optional feature: define CLUSTER_SCHED_OVFCNT_EN to add the saturating ovf_count output.
module cluster_scheduler #(
  parameter int MXPAD      = 1536,
  parameter int MXADRB     = 11,
  parameter int MXCLUSTERS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_strobe,
  input  logic [MXPAD-1:0]     vpf_in,
  input  logic [3*MXPAD-1:0]   cnt_in,
  output logic                 busy,
  output logic                 clust_valid,
  input  logic                 clust_ready,
  output logic [MXADRB+2:0]    clust_data,
  output logic                 clust_last,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 frame_drop
`ifdef CLUSTER_SCHED_OVFCNT_EN
  ,
  output logic [15:0]          ovf_count
`endif
);

  localparam int EW = $clog2(MXCLUSTERS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t               state_q;
  logic [MXPAD-1:0]     shadow_q;
  logic [3*MXPAD-1:0]   cnt_q;
  logic [EW-1:0]        emitted_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [MXADRB+2:0]    data_q;
  logic                 last_q;
  logic                 done_q;
  logic                 overflow_q;
  logic                 drop_q;

  logic [2:0]           cnt_arr [MXPAD];
  logic [MXPAD-1:0]     src_vec;
  logic [MXPAD-1:0]     rest_vec;
  logic [MXADRB-1:0]    nxt_idx;
  logic                 nxt_found;
  logic                 rest_any;
  logic [EW-1:0]        emitted_nxt;
  logic                 nxt_last;
  logic                 handshake;
  logic                 overflow_d;
  logic                 frame_drop_d;

  for (genvar gi = 0; gi < MXPAD; gi++) begin : g_cnt
    assign cnt_arr[gi] = cnt_q[3*gi +: 3];
  end

  function automatic logic [MXADRB-1:0] lowest(input logic [MXPAD-1:0] v);
    lowest = '0;
    for (int k = MXPAD - 1; k >= 0; k--) begin
      if (v[k]) lowest = MXADRB'(k);
    end
  endfunction

  // In EMIT the shadow still holds the word on the bus; candidates exclude it.
  always_comb begin
    src_vec = shadow_q;
    if (state_q == S_EMIT) src_vec[data_q[MXADRB-1:0]] = 1'b0;
    nxt_idx   = lowest(src_vec);
    nxt_found = |src_vec;
    rest_vec  = src_vec;
    rest_vec[nxt_idx] = 1'b0;
    rest_any  = |rest_vec;
    emitted_nxt  = (state_q == S_EMIT) ? emitted_q + 1'b1 : '0;
    nxt_last     = !rest_any || (emitted_nxt == EW'(MXCLUSTERS - 1));
    handshake    = (state_q == S_EMIT) && valid_q && clust_ready;
    overflow_d   = handshake && last_q && nxt_found;
    frame_drop_d = frame_strobe && (state_q != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      cnt_q      <= '0;
      emitted_q  <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      overflow_q <= overflow_d;
      drop_q     <= frame_drop_d;
      case (state_q)
        S_IDLE: begin
          if (frame_strobe) begin
            shadow_q  <= vpf_in;
            cnt_q     <= cnt_in;
            emitted_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!nxt_found) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            valid_q <= 1'b1;
            data_q  <= {cnt_arr[nxt_idx], nxt_idx};
            last_q  <= nxt_last;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (handshake) begin
            shadow_q <= src_vec;
            if (last_q) begin
              valid_q <= 1'b0;
              data_q  <= '0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              emitted_q <= emitted_nxt;
              data_q    <= {cnt_arr[nxt_idx], nxt_idx};
              last_q    <= nxt_last;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign clust_valid = valid_q;
  assign clust_data  = data_q;
  assign clust_last  = last_q;
  assign frame_done  = done_q;
  assign overflow    = overflow_q;
  assign frame_drop  = drop_q;

`ifdef CLUSTER_SCHED_OVFCNT_EN
  logic [15:0] ovf_count_q;
  logic [16:0] ovf_sum;

  always_comb ovf_sum = {1'b0, ovf_count_q} + 17'(overflow_d) + 17'(frame_drop_d);

  always_ff @(posedge clock) begin
    if (reset)               ovf_count_q <= '0;
    else if (ovf_sum[16])    ovf_count_q <= 16'hFFFF;
    else                     ovf_count_q <= ovf_sum[15:0];
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule
